// File: rtl/pp_pipeline_accel_mul_rr_sched.sv
// Round-robin scheduler sharing one ce-gated pipelined multiplier among NUM_REQ requesters.
// Define PP_MUL_SCHED_PERF_EN to add the issue/stall performance counters and perf_* ports.
module pp_pipeline_accel_mul_rr_sched #(
   parameter int NUM_REQ = 4,
   parameter int A_W     = 16,
   parameter int B_W     = 11,
   parameter int P_W     = A_W + B_W,
   parameter int MUL_LAT = 2,
   localparam int ID_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [NUM_REQ-1:0]     req_valid,
   output logic [NUM_REQ-1:0]     req_ready,
   input  logic [NUM_REQ*A_W-1:0] req_a,
   input  logic [NUM_REQ*B_W-1:0] req_b,
   output logic                   mul_ce,
   output logic [A_W-1:0]         mul_din0,
   output logic [B_W-1:0]         mul_din1,
   input  logic [P_W-1:0]         mul_dout,
   output logic                   res_valid,
   input  logic                   res_ready,
   output logic [ID_W-1:0]        res_id,
   output logic [P_W-1:0]         res_data
`ifdef PP_MUL_SCHED_PERF_EN
   ,
   input  logic                   perf_clr,
   output logic [31:0]            perf_issue_cnt,
   output logic [31:0]            perf_stall_cnt
`endif
);

   logic                w_ce;
   logic                w_gnt_vld;
   logic [ID_W-1:0]     w_gnt_id;
   logic [NUM_REQ-1:0]  w_ready;
   logic                w_xfer;

   logic [ID_W-1:0]     r_ptr;
   logic [MUL_LAT-1:0]  r_vld;
   logic [ID_W-1:0]     r_tag [MUL_LAT];

   // The whole multiplier freezes while a finished result waits downstream.
   assign w_ce = reset | ~(r_vld[MUL_LAT-1] & ~res_ready);

   always_comb begin : p_arb
      logic [ID_W-1:0] sel;
      // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
      sel       = '0;
      w_gnt_vld = 1'b0;
      w_gnt_id  = '0;
      w_ready   = '0;
      mul_din0  = '0;
      mul_din1  = '0;
      for (int i = 1; i <= NUM_REQ; i++) begin
         sel = ID_W'((int'(r_ptr) + i) % NUM_REQ);
         if (!w_gnt_vld && req_valid[sel]) begin
            w_gnt_vld = 1'b1;
            w_gnt_id  = sel;
         end
      end
      if (w_gnt_vld && w_ce && !reset) begin
         w_ready[w_gnt_id] = 1'b1;
         mul_din0          = req_a[w_gnt_id*A_W +: A_W];
         mul_din1          = req_b[w_gnt_id*B_W +: B_W];
      end
   end

   assign w_xfer    = |(req_valid & w_ready);
   assign req_ready = w_ready;
   assign mul_ce    = w_ce;

   // NOTE: state registers use non-blocking assignments so every stage samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_ptr <= ID_W'(NUM_REQ - 1);
         r_vld <= '0;
         // NOTE: the tag array is a handful of flops and is cleared so res_id reads 0; the multiplier's data regs stay unreset.
         for (int s = 0; s < MUL_LAT; s++) r_tag[s] <= '0;
      end else if (w_ce) begin
         r_vld[0] <= w_xfer;
         r_tag[0] <= w_gnt_id;
         for (int s = 1; s < MUL_LAT; s++) begin
            r_vld[s] <= r_vld[s-1];
            r_tag[s] <= r_tag[s-1];
         end
         if (w_xfer) r_ptr <= w_gnt_id;
      end
   end

   assign res_valid = r_vld[MUL_LAT-1];
   assign res_id    = r_tag[MUL_LAT-1];
   assign res_data  = mul_dout;

`ifdef PP_MUL_SCHED_PERF_EN
   logic [31:0] r_issue_cnt;
   logic [31:0] r_stall_cnt;

   always_ff @(posedge clk) begin
      if (reset || perf_clr) begin
         r_issue_cnt <= '0;
         r_stall_cnt <= '0;
      end else begin
         if (w_xfer && (r_issue_cnt != 32'hFFFF_FFFF)) r_issue_cnt <= r_issue_cnt + 32'd1;
         if (!w_ce && (r_stall_cnt != 32'hFFFF_FFFF)) r_stall_cnt <= r_stall_cnt + 32'd1;
      end
   end

   assign perf_issue_cnt = r_issue_cnt;
   assign perf_stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_pp_pipeline_accel_mul_rr_sched.sv
// Directed bench for pp_pipeline_accel_mul_rr_sched with a two-stage ce-gated multiplier model.
// Perf counter checks are compiled in when PP_MUL_SCHED_PERF_EN is defined.
module tb_pp_pipeline_accel_mul_rr_sched;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  req_valid;
   logic [3:0]  req_ready;
   logic [63:0] req_a;
   logic [43:0] req_b;
   logic        mul_ce;
   logic [15:0] mul_din0;
   logic [10:0] mul_din1;
   logic [26:0] mul_dout;
   logic        res_valid;
   logic        res_ready;
   logic [1:0]  res_id;
   logic [26:0] res_data;
`ifdef PP_MUL_SCHED_PERF_EN
   logic        perf_clr;
   logic [31:0] perf_issue_cnt;
   logic [31:0] perf_stall_cnt;
`endif

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   pp_pipeline_accel_mul_rr_sched dut (
      .clk       (clk),
      .reset     (reset),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_a     (req_a),
      .req_b     (req_b),
      .mul_ce    (mul_ce),
      .mul_din0  (mul_din0),
      .mul_din1  (mul_din1),
      .mul_dout  (mul_dout),
      .res_valid (res_valid),
      .res_ready (res_ready),
      .res_id    (res_id),
      .res_data  (res_data)
`ifdef PP_MUL_SCHED_PERF_EN
      ,
      .perf_clr       (perf_clr),
      .perf_issue_cnt (perf_issue_cnt),
      .perf_stall_cnt (perf_stall_cnt)
`endif
   );

   // Multiplier: operand register then product register, both ce-gated, no reset.
   logic [15:0] m_a;
   logic [10:0] m_b;
   logic [26:0] m_p;
   always @(posedge clk) begin
      if (mul_ce) begin
         m_a <= mul_din0;
         m_b <= mul_din1;
         m_p <= 27'(m_a) * 27'(m_b);
      end
   end
   assign mul_dout = m_p;

   typedef struct {
      logic [3:0]  rv;
      logic        rr;
      logic [3:0]  exp_rdy;
      logic        exp_vld;
      logic [1:0]  exp_id;
      logic [26:0] exp_data;
   } vec_t;

   vec_t tbl [12];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // One cycle window: drive at the falling edge, settle, then the caller checks before the rising edge.
   task automatic win(input logic [3:0] rv, input logic rr);
      @(negedge clk);
      req_valid = rv;
      res_ready = rr;
      #1;
   endtask

   task automatic set_op(input int i, input logic [15:0] a, input logic [10:0] b);
      req_a[i*16 +: 16] = a;
      req_b[i*11 +: 11] = b;
   endtask

   task automatic check_res(input string name, input logic vld, input logic [1:0] id, input logic [26:0] data);
      check({name, ".res_valid"}, 32'(res_valid), 32'(vld));
      if (vld) begin
         check({name, ".res_id"}, 32'(res_id), 32'(id));
         check({name, ".res_data"}, 32'(res_data), 32'(data));
      end
   endtask

   initial begin
      reset     = 1'b1;
      req_valid = '0;
      res_ready = 1'b0;
      req_a     = '0;
      req_b     = '0;
`ifdef PP_MUL_SCHED_PERF_EN
      perf_clr  = 1'b0;
`endif

      // Operands per requester for the table: products 6, 15, 35, 77.
      tbl[0]  = '{4'b1111, 1'b1, 4'b0100, 1'b0, 2'd0, 27'd0};
      tbl[1]  = '{4'b1111, 1'b1, 4'b1000, 1'b0, 2'd0, 27'd0};
      tbl[2]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 2'd2, 27'd35};
      tbl[3]  = '{4'b1111, 1'b1, 4'b0010, 1'b1, 2'd3, 27'd77};
      tbl[4]  = '{4'b1111, 1'b1, 4'b0100, 1'b1, 2'd0, 27'd6};
      tbl[5]  = '{4'b0101, 1'b1, 4'b0001, 1'b1, 2'd1, 27'd15};
      tbl[6]  = '{4'b0101, 1'b1, 4'b0100, 1'b1, 2'd2, 27'd35};
      tbl[7]  = '{4'b0101, 1'b1, 4'b0001, 1'b1, 2'd0, 27'd6};
      tbl[8]  = '{4'b0000, 1'b1, 4'b0000, 1'b1, 2'd2, 27'd35};
      tbl[9]  = '{4'b0000, 1'b1, 4'b0000, 1'b1, 2'd0, 27'd6};
      tbl[10] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 27'd0};
      tbl[11] = '{4'b1000, 1'b1, 4'b1000, 1'b0, 2'd0, 27'd0};

      // Reset state: no grants even with requests pending, ce forced high.
      win(4'b1111, 1'b0);
      check("rst.req_ready", 32'(req_ready), 32'h0);
      check("rst.mul_ce", 32'(mul_ce), 32'h1);
      win(4'b0000, 1'b1);
      check("rst.res_valid", 32'(res_valid), 32'h0);
      check("rst.res_id", 32'(res_id), 32'h0);

      // Single requester with maximum operands.
      reset = 1'b0;
      set_op(1, 16'hFFFF, 11'h7FF);
      win(4'b0010, 1'b1);
      check("single.req_ready", 32'(req_ready), 32'b0010);
      check("single.mul_din0", 32'(mul_din0), 32'hFFFF);
      check("single.res0", 32'(res_valid), 32'h0);
      win(4'b0000, 1'b1);
      check("single.mul_din0_idle", 32'(mul_din0), 32'h0);
      check("single.res1", 32'(res_valid), 32'h0);
      win(4'b0000, 1'b1);
      check_res("single.res2", 1'b1, 2'd1, 27'h7FEF801);

      set_op(0, 16'd3, 11'd2);
      set_op(1, 16'd5, 11'd3);
      set_op(2, 16'd7, 11'd5);
      set_op(3, 16'd11, 11'd7);

      // Round-robin rotation, sparse requesters and bubbles.
      for (int k = 0; k < 12; k++) begin
         win(tbl[k].rv, tbl[k].rr);
         check($sformatf("tbl%0d.req_ready", k), 32'(req_ready), 32'(tbl[k].exp_rdy));
         check($sformatf("tbl%0d.mul_ce", k), 32'(mul_ce), 32'h1);
         check_res($sformatf("tbl%0d", k), tbl[k].exp_vld, tbl[k].exp_id, tbl[k].exp_data);
      end

      // Backpressure for 5 cycles with a result pending, then release with same-cycle issue.
      win(4'b1111, 1'b1);
      check("bp.pre_ready", 32'(req_ready), 32'b0001);
      check("bp.pre_res", 32'(res_valid), 32'h0);
      for (int k = 0; k < 5; k++) begin
         win(4'b1111, 1'b0);
         check($sformatf("bp%0d.mul_ce", k), 32'(mul_ce), 32'h0);
         check($sformatf("bp%0d.req_ready", k), 32'(req_ready), 32'h0);
         check_res($sformatf("bp%0d", k), 1'b1, 2'd3, 27'd77);
      end
      win(4'b1111, 1'b1);
      check("bp.rel_mul_ce", 32'(mul_ce), 32'h1);
      check("bp.rel_ready", 32'(req_ready), 32'b0010);
      check_res("bp.rel", 1'b1, 2'd3, 27'd77);
      win(4'b0000, 1'b1);
      check_res("bp.next0", 1'b1, 2'd0, 27'd6);
      win(4'b0000, 1'b1);
      check_res("bp.next1", 1'b1, 2'd1, 27'd15);
      win(4'b0000, 1'b1);
      check_res("bp.empty", 1'b0, 2'd0, 27'd0);

      // Reset with two products issued: none may emerge, priority returns to req0.
      win(4'b0011, 1'b1);
      check("rstmid.g0", 32'(req_ready), 32'b0001);
      win(4'b0011, 1'b1);
      check("rstmid.g1", 32'(req_ready), 32'b0010);
      reset = 1'b1;
      win(4'b0011, 1'b0);
      check("rstmid.ready", 32'(req_ready), 32'h0);
      check("rstmid.mul_ce", 32'(mul_ce), 32'h1);
      win(4'b0000, 1'b0);
      reset = 1'b0;
      win(4'b0000, 1'b1);
      check("rstmid.res0", 32'(res_valid), 32'h0);
      win(4'b0000, 1'b1);
      check("rstmid.res1", 32'(res_valid), 32'h0);
      win(4'b1111, 1'b1);
      check("rstmid.first_grant", 32'(req_ready), 32'b0001);
      check("rstmid.res2", 32'(res_valid), 32'h0);
      win(4'b0000, 1'b1);
      check("rstmid.res3", 32'(res_valid), 32'h0);
      win(4'b0000, 1'b1);
      check_res("rstmid.post", 1'b1, 2'd0, 27'd6);
      win(4'b0000, 1'b1);

`ifdef PP_MUL_SCHED_PERF_EN
      perf_clr = 1'b1;
      win(4'b0000, 1'b1);
      perf_clr = 1'b0;
      win(4'b0000, 1'b1);
      check("perf.clr_issue", perf_issue_cnt, 32'd0);
      check("perf.clr_stall", perf_stall_cnt, 32'd0);
      for (int k = 0; k < 10; k++) win(4'b1111, 1'b1);
      for (int k = 0; k < 3; k++) win(4'b0000, 1'b0);
      win(4'b0000, 1'b1);
      check("perf.issue", perf_issue_cnt, 32'd10);
      check("perf.stall", perf_stall_cnt, 32'd3);
      perf_clr = 1'b1;
      win(4'b0000, 1'b1);
      perf_clr = 1'b0;
      check("perf.clr2_issue", perf_issue_cnt, 32'd0);
      check("perf.clr2_stall", perf_stall_cnt, 32'd0);
      for (int k = 0; k < 3; k++) win(4'b0000, 1'b1);
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
